// File: rtl/fetch_run_controller_pkg.sv
// Shared definitions for the fetch run controller.
// State encoding, default timing parameters and width helper.
package fetch_run_controller_pkg;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BREAK = 2'd2
    } state_t;

    localparam int DEF_DB_CYCLES = 1000000;
    localparam int DEF_TICK_DIV  = 50000000;
    localparam int DEF_CNT_W     = 16;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fetch_run_controller_button_debouncer.sv
// Pushbutton synchronizer, stable-level filter and rise pulse.
// Level flips after DB_CYCLES consecutive cycles of a new value.
module button_debouncer
    import fetch_run_controller_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic Clk,
    input  logic Reset,
    input  logic BtnIn,
    output logic Level,
    output logic RisePulse
);

    localparam int CW = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          rise_q;
    logic          rise_d;

    // Count cycles the synchronized input disagrees with the level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Synchronizer chain and filter state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= BtnIn;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
        end
    end

    assign Level     = level_q;
    assign RisePulse = rise_q;

endmodule

// File: rtl/fetch_run_controller.sv
// Step / run / breakpoint sequencer for the fetch PC enable.
// Emits one-cycle PC advance pulses and counts them.
module fetch_run_controller
    import fetch_run_controller_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES,
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             BtnStep,
    input  logic             BtnRun,
    input  logic [31:0]      PCResult,
    input  logic [31:0]      BreakAddr,
    input  logic             BreakEn,
    output logic             PCEnable,
    output logic             Running,
    output logic             BreakHit,
    output logic [CNT_W-1:0] AdvanceCount
);

    localparam int TW = cnt_width(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    state_t           state_q;
    state_t           state_d;
    logic [TW-1:0]    tick_q;
    logic [TW-1:0]    tick_d;
    logic             skip_q;
    logic             skip_d;
    logic             pcen_q;
    logic             pcen_d;
    logic [CNT_W-1:0] adv_q;
    logic [CNT_W-1:0] adv_d;

    logic             step_p;
    logic             run_p;
    logic             bp_match;
    logic [1:0]       lvl_unused;

    button_debouncer #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_step (
        .Clk       (Clk),
        .Reset     (Reset),
        .BtnIn     (BtnStep),
        .Level     (lvl_unused[0]),
        .RisePulse (step_p)
    );

    button_debouncer #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_run (
        .Clk       (Clk),
        .Reset     (Reset),
        .BtnIn     (BtnRun),
        .Level     (lvl_unused[1]),
        .RisePulse (run_p)
    );

    assign bp_match = BreakEn && (PCResult == BreakAddr) && !skip_q;

    // Next state, tick schedule and pulse request; run_p beats step_p.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        skip_d  = skip_q;
        pcen_d  = 1'b0;
        unique case (state_q)
            ST_HALT: begin
                if (run_p) begin
                    state_d = ST_RUN;
                    tick_d  = '0;
                end else if (step_p) begin
                    pcen_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (run_p) begin
                    state_d = ST_HALT;
                    tick_d  = '0;
                end else if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (bp_match) begin
                        state_d = ST_BREAK;
                    end else begin
                        pcen_d = 1'b1;
                        skip_d = 1'b0;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            ST_BREAK: begin
                if (run_p) begin
                    state_d = ST_RUN;
                    tick_d  = '0;
                    skip_d  = 1'b1;
                end else if (step_p) begin
                    pcen_d  = 1'b1;
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
        adv_d = pcen_d ? adv_q + CNT_W'(1) : adv_q;
    end

    // Controller registers; reset drops any pending pulse.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_HALT;
            tick_q  <= '0;
            skip_q  <= 1'b0;
            pcen_q  <= 1'b0;
            adv_q   <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            skip_q  <= skip_d;
            pcen_q  <= pcen_d;
            adv_q   <= adv_d;
        end
    end

    assign PCEnable     = pcen_q;
    assign Running      = (state_q == ST_RUN);
    assign BreakHit     = (state_q == ST_BREAK);
    assign AdvanceCount = adv_q;

endmodule

// File: tb/tb_fetch_run_controller.sv
// Bench for fetch_run_controller with DB_CYCLES=4, TICK_DIV=8.
// Cycle model checked every clock plus directed literal checks.
module tb_fetch_run_controller;

    localparam int DB = 4;
    localparam int TD = 8;
    localparam int M_HALT = 0;
    localparam int M_RUN = 1;
    localparam int M_BRK = 2;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        BtnStep = 1'b0;
    logic        BtnRun = 1'b0;
    logic [31:0] pc;
    logic [31:0] BreakAddr = 32'h0;
    logic        BreakEn = 1'b0;
    logic        PCEnable;
    logic        Running;
    logic        BreakHit;
    logic [15:0] AdvanceCount;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;

    fetch_run_controller #(
        .DB_CYCLES (DB),
        .TICK_DIV  (TD),
        .CNT_W     (16)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .BtnStep      (BtnStep),
        .BtnRun       (BtnRun),
        .PCResult     (pc),
        .BreakAddr    (BreakAddr),
        .BreakEn      (BreakEn),
        .PCEnable     (PCEnable),
        .Running      (Running),
        .BreakHit     (BreakHit),
        .AdvanceCount (AdvanceCount)
    );

    always #5 Clk = ~Clk;

    // Fetch-unit stand-in: PC steps by 4 on every enable.
    always @(posedge Clk) begin
        if (Reset) pc <= 32'h0;
        else if (PCEnable) pc <= pc + 32'd4;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    // ---------------- behavioural model ----------------
    bit          mvalid = 0;
    logic [15:0] hs, hr;
    bit          lvl_s, lvl_r, pend_s, pend_r;
    int          mode, runcyc;
    bit          skip, e_pcen;
    logic [15:0] e_cnt;

    function automatic bit win_all(input logic [15:0] h, input bit v);
        for (int i = 2; i < DB + 2; i++)
            if (h[i] != v) return 0;
        return 1;
    endfunction

    task automatic model_edge(input bit r, input bit bs, input bit br,
                              input bit be, input logic [31:0] ba,
                              input logic [31:0] pcv);
        bit sp, rp;
        if (r) begin
            hs = '0; hr = '0;
            lvl_s = 0; lvl_r = 0; pend_s = 0; pend_r = 0;
            mode = M_HALT; runcyc = 0; skip = 0;
            e_pcen = 0; e_cnt = '0; mvalid = 1;
            return;
        end
        sp = pend_s;
        rp = pend_r;
        hs = {hs[14:0], bs};
        hr = {hr[14:0], br};
        pend_s = 0;
        pend_r = 0;
        if (win_all(hs, !lvl_s)) begin lvl_s = !lvl_s; pend_s = lvl_s; end
        if (win_all(hr, !lvl_r)) begin lvl_r = !lvl_r; pend_r = lvl_r; end
        e_pcen = 0;
        if (rp) begin
            if (mode == M_RUN) mode = M_HALT;
            else begin
                if (mode == M_BRK) skip = 1;
                mode = M_RUN;
                runcyc = 0;
            end
        end else if (sp && mode != M_RUN) begin
            e_pcen = 1;
            mode = M_HALT;
        end else if (mode == M_RUN) begin
            runcyc++;
            if (runcyc % TD == 0) begin
                if (be && pcv == ba && !skip) mode = M_BRK;
                else begin e_pcen = 1; skip = 0; end
            end
        end
        if (e_pcen) e_cnt = e_cnt + 16'd1;
    endtask

    // Every-cycle comparison against the model.
    initial begin
        bit r, bs, br, be;
        logic [31:0] ba, pcv;
        forever begin
            @(posedge Clk);
            r = Reset; bs = BtnStep; br = BtnRun;
            be = BreakEn; ba = BreakAddr; pcv = pc;
            #1;
            cyc++;
            model_edge(r, bs, br, be, ba, pcv);
            if (mvalid) begin
                n_tests++;
                if (PCEnable !== e_pcen || Running !== (mode == M_RUN) ||
                    BreakHit !== (mode == M_BRK) || AdvanceCount !== e_cnt) begin
                    n_fail++;
                    $display("FAIL model cyc %0d: got en=%b run=%b brk=%b cnt=%0d want en=%b run=%b brk=%b cnt=%0d",
                             cyc, PCEnable, Running, BreakHit, AdvanceCount,
                             e_pcen, mode == M_RUN, mode == M_BRK, e_cnt);
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    function automatic bit sig(input int w);
        case (w)
            0: return PCEnable;
            1: return Running;
            2: return BreakHit;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_until(input int w, input bit v, input int bound,
                              output int pulses);
        int e;
        e = 0;
        pulses = 0;
        while (sig(w) !== v && e < bound) begin
            @(posedge Clk); #1;
            e++;
            if (PCEnable) pulses++;
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        BtnStep = 0; BtnRun = 0; Reset = 1;
        @(negedge Clk);
        Reset = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int np, first, last, gapbad;
        logic [31:0] pcs [3];
        logic [15:0] c0;

        do_reset();
        check("rst_pcen", PCEnable, 0);
        check("rst_run", Running, 0);
        check("rst_brk", BreakHit, 0);
        check("rst_cnt", AdvanceCount, 0);

        // 1: bouncy step press then long hold
        @(negedge Clk); BtnStep = 1;
        @(negedge Clk); BtnStep = 0;
        @(negedge Clk); BtnStep = 1;
        np = 0; first = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge Clk); #1;
            if (PCEnable) begin np++; if (first == 0) first = i; end
        end
        check("s1_pulses", np, 1);
        check("s1_latency", first, 7);
        check("s1_cnt", AdvanceCount, 1);
        check("s1_halt", {Running, BreakHit}, 0);
        @(negedge Clk); BtnStep = 0;
        idle(10);

        // 2: free run, then halt
        do_reset();
        @(negedge Clk); BtnRun = 1;
        wait_until(1, 1, 20, np);
        check("s2_running", Running, 1);
        np = 0; last = 0; gapbad = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge Clk); #1;
            if (PCEnable) begin
                np++;
                if (i - last != TD) gapbad++;
                last = i;
            end
        end
        check("s2_pulses", np, 5);
        check("s2_gaps", gapbad, 0);
        check("s2_cnt", AdvanceCount, 5);
        @(negedge Clk); BtnRun = 0;
        idle(10);
        @(negedge Clk); BtnRun = 1;
        wait_until(1, 0, 20, np);
        check("s2_halted", Running, 0);
        c0 = AdvanceCount;
        wait_until(0, 1, 20, np);
        check("s2_no_more", np, 0);
        check("s2_cnt_hold", AdvanceCount, c0);
        @(negedge Clk); BtnRun = 0;
        idle(10);

        // 3: breakpoint at 0x0C, then resume past it
        do_reset();
        BreakEn = 1; BreakAddr = 32'h0C;
        @(negedge Clk); BtnRun = 1;
        np = 0;
        for (int i = 0; i < 60 && !BreakHit; i++) begin
            @(posedge Clk); #1;
            if (PCEnable) begin
                if (np < 3) pcs[np] = pc;
                np++;
            end
        end
        check("s3_brk", BreakHit, 1);
        check("s3_pulses", np, 3);
        check("s3_pc0", pcs[0], 32'h0);
        check("s3_pc1", pcs[1], 32'h4);
        check("s3_pc2", pcs[2], 32'h8);
        check("s3_pc_held", pc, 32'h0C);
        @(negedge Clk); BtnRun = 0; BreakEn = 0; BreakAddr = 32'h40;
        idle(10);
        check("s3_brk_sticky", BreakHit, 1);
        BreakEn = 1; BreakAddr = 32'h0C;
        @(negedge Clk); BtnRun = 1;
        wait_until(0, 1, 30, np);
        check("s3_skip_pulse", PCEnable, 1);
        check("s3_skip_pc", pc, 32'h0C);
        check("s3_brk_clr", BreakHit, 0);
        @(posedge Clk); #1;
        check("s3_pc_next", pc, 32'h10);
        @(negedge Clk); BtnRun = 0;
        idle(10);

        // 4: step out of BREAK
        do_reset();
        BreakEn = 1; BreakAddr = 32'h0;
        @(negedge Clk); BtnRun = 1;
        wait_until(2, 1, 30, np);
        check("s4_brk", BreakHit, 1);
        check("s4_cnt0", AdvanceCount, 0);
        @(negedge Clk); BtnRun = 0;
        idle(10);
        @(negedge Clk); BtnStep = 1;
        wait_until(0, 1, 20, np);
        check("s4_pulse", PCEnable, 1);
        @(posedge Clk); #1;
        check("s4_state", {Running, BreakHit}, 0);
        check("s4_cnt", AdvanceCount, 1);
        @(negedge Clk); BtnStep = 0;
        idle(10);

        // 5: step and run together in HALT
        do_reset();
        BreakEn = 0;
        @(negedge Clk); BtnStep = 1; BtnRun = 1;
        wait_until(1, 1, 20, np);
        check("s5_running", Running, 1);
        check("s5_no_pulse", np, 0);
        check("s5_cnt", AdvanceCount, 0);
        @(negedge Clk); BtnStep = 0; BtnRun = 0;
        idle(10);

        // 6: reset mid-RUN at tick 7
        do_reset();
        @(negedge Clk); BtnRun = 1;
        wait_until(1, 1, 20, np);
        check("s6_running", Running, 1);
        @(negedge Clk); BtnRun = 0;
        repeat (7) @(posedge Clk);
        @(negedge Clk);
        check("s6_pre_cnt", AdvanceCount, 0);
        check("s6_pre_run", Running, 1);
        Reset = 1;
        @(posedge Clk); #1;
        check("s6_pcen", PCEnable, 0);
        check("s6_outs", {Running, BreakHit}, 0);
        check("s6_cnt", AdvanceCount, 0);
        @(negedge Clk); Reset = 0;
        idle(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
